egress_port_arbiter: RTL and testbench

//  Shares one serial egress link (TX_Unit serializer) among N switch ingress queues.

---
 rtl/l2sw_pkg.sv | 31 +++
 rtl/egress_port_arbiter_rr_pick.sv | 25 ++
 rtl/egress_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_egress_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2sw_pkg.sv
// Shared L2 switch definitions: frame field layout, SFD constants and egress arbiter states.
package l2sw_pkg;

    localparam int DEPTH      = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int SFD_WIDTH  = 4;

    localparam logic [SFD_WIDTH-1:0]  SFD_PATTERN    = 4'b1010;
    localparam logic [ADDR_WIDTH-1:0] BROADCAST_ADDR = 4'hF;

    localparam int SFD_MSB = 15;
    localparam int SFD_LSB = 12;
    localparam int DST_MSB = 11;
    localparam int DST_LSB = 8;
    localparam int SRC_MSB = 7;
    localparam int SRC_LSB = 4;
    localparam int PAY_MSB = 3;
    localparam int PAY_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } arb_state_t;

    function automatic logic [SFD_WIDTH-1:0] frame_sfd(input logic [DEPTH-1:0] frame);
        return frame[SFD_MSB:SFD_LSB];
    endfunction

endpackage

// File: rtl/egress_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching last+1, last+2, ... mod N_PORTS.
module rr_pick #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned IDX_W   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N_PORTS; k++) begin
            int unsigned cand;
            cand = (32'(last) + k) % N_PORTS;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/egress_port_arbiter.sv
// Round-robin egress arbiter feeding one TX serializer, with busy timeout and inter-frame gap.
// Optional SFD screening at grant time is enabled by defining EGRESS_ARB_SFD_CHECK_EN.
module egress_port_arbiter
    import l2sw_pkg::*;
#(
    parameter int N_PORTS      = 4,
    parameter int DEPTH        = 16,
    parameter int IFG_CYCLES   = 2,
    parameter int BUSY_TIMEOUT = 4,
    parameter int IDX_W        = $clog2(N_PORTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PORTS-1:0]         req,
    input  logic [N_PORTS*DEPTH-1:0]   frame_in,
    output logic [N_PORTS-1:0]         ack,
    output logic [DEPTH-1:0]           tx_frame,
    output logic                       frame_tx_valid,
    input  logic                       tx_busy,
    output logic [IDX_W-1:0]           grant_idx,
    output logic                       arb_active,
`ifdef EGRESS_ARB_SFD_CHECK_EN
    output logic                       drop_pulse,
`endif
    output logic                       tx_timeout
);

    localparam int TMR_W = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);
    localparam int GAP_W = (IFG_CYCLES < 1) ? 1 : $clog2(IFG_CYCLES + 1);

    arb_state_t         r_state, w_state_nxt;
    logic [TMR_W-1:0]   r_timer, w_timer_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic [IDX_W-1:0]   r_last, w_last_nxt;
    logic [DEPTH-1:0]   r_tx_frame, w_frame_nxt;
    logic               r_valid, w_valid_nxt;
    logic [N_PORTS-1:0] r_ack, w_ack_nxt;
    logic [IDX_W-1:0]   r_grant, w_grant_nxt;
    logic               r_timeout, w_timeout_nxt;
    logic               r_drop, w_drop_nxt;

    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [DEPTH-1:0]   w_pick_frame;
    logic               w_sfd_ok;

    rr_pick #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .last  (r_last),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    assign w_pick_frame = frame_in[32'(w_pick_idx)*DEPTH +: DEPTH];

`ifdef EGRESS_ARB_SFD_CHECK_EN
    assign w_sfd_ok   = (w_pick_frame[DEPTH-1 -: SFD_WIDTH] == SFD_PATTERN);
    assign drop_pulse = r_drop;
`else
    assign w_sfd_ok   = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_gap      <= '0;
            r_last     <= IDX_W'(N_PORTS - 1);
            r_tx_frame <= '0;
            r_valid    <= 1'b0;
            r_ack      <= '0;
            r_grant    <= '0;
            r_timeout  <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_gap      <= w_gap_nxt;
            r_last     <= w_last_nxt;
            r_tx_frame <= w_frame_nxt;
            r_valid    <= w_valid_nxt;
            r_ack      <= w_ack_nxt;
            r_grant    <= w_grant_nxt;
            r_timeout  <= w_timeout_nxt;
            r_drop     <= w_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_gap_nxt     = r_gap;
        w_last_nxt    = r_last;
        w_frame_nxt   = r_tx_frame;
        w_valid_nxt   = 1'b0;
        w_ack_nxt     = '0;
        w_grant_nxt   = r_grant;
        w_timeout_nxt = 1'b0;
        w_drop_nxt    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_last_nxt             = w_pick_idx;
                    w_grant_nxt            = w_pick_idx;
                    w_ack_nxt[w_pick_idx]  = 1'b1;
                    if (w_sfd_ok) begin
                        w_frame_nxt = w_pick_frame;
                        w_valid_nxt = 1'b1;
                        w_timer_nxt = TMR_W'(BUSY_TIMEOUT);
                        w_state_nxt = ST_WAIT_BUSY;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end
            end
            ST_WAIT_BUSY: begin
                // Timeout fires on the edge the timer would reach zero, i.e. BUSY_TIMEOUT cycles after the load strobe.
                if (tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_timer <= TMR_W'(1)) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (IFG_CYCLES == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_gap_nxt   = GAP_W'(IFG_CYCLES);
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap <= GAP_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap - GAP_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign ack            = r_ack;
    assign tx_frame       = r_tx_frame;
    assign frame_tx_valid = r_valid;
    assign grant_idx      = r_grant;
    assign tx_timeout     = r_timeout;
    assign arb_active     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_egress_port_arbiter.sv
// Directed bench for egress_port_arbiter with a simple serializer model that stays busy until 17 cycles after each load.
module tb_egress_port_arbiter;

    localparam int NP = 4;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     req = '0;
    logic [NP*DW-1:0]  frame_in = '0;
    logic [NP-1:0]     ack;
    logic [DW-1:0]     tx_frame;
    logic              frame_tx_valid;
    logic              tx_busy;
    logic [1:0]        grant_idx;
    logic              arb_active;
    logic              tx_timeout;
`ifdef EGRESS_ARB_SFD_CHECK_EN
    logic              drop_pulse;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic ser_en = 1'b1;
    int ser_cnt;
    int gidx_q[$];
    int gcyc_q[$];

    egress_port_arbiter #(
        .N_PORTS      (NP),
        .DEPTH        (DW),
        .IFG_CYCLES   (2),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .frame_in       (frame_in),
        .ack            (ack),
        .tx_frame       (tx_frame),
        .frame_tx_valid (frame_tx_valid),
        .tx_busy        (tx_busy),
        .grant_idx      (grant_idx),
        .arb_active     (arb_active),
`ifdef EGRESS_ARB_SFD_CHECK_EN
        .drop_pulse     (drop_pulse),
`endif
        .tx_timeout     (tx_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) ser_cnt <= 0;
        else if (frame_tx_valid && ser_en) ser_cnt <= 16;
        else if (ser_cnt != 0) ser_cnt <= ser_cnt - 1;
    end
    assign tx_busy = (ser_cnt != 0);

    always @(negedge clk) begin
        if (!rst && frame_tx_valid) begin
            gidx_q.push_back(int'(grant_idx));
            gcyc_q.push_back(cyc);
        end
        if (!rst && ack != '0) begin
            total++;
            if (ack !== (4'b0001 << grant_idx)) begin
                bad++;
                $display("FAIL ack_onehot: ack=%b grant_idx=%0d", ack, grant_idx);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        gidx_q.delete();
        gcyc_q.delete();
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k;
        k = 0;
        while (gidx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (gidx_q.size() < n) begin
            total++;
            bad++;
            $display("FAIL wait_grants: got=%0d want=%0d", gidx_q.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (arb_active && k < budget) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (arb_active !== 1'b0) begin
            bad++;
            $display("FAIL wait_idle: arb_active=%b want=0", arb_active);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total += 6;
        if (tx_frame !== 16'h0)       begin bad++; $display("FAIL rst_tx_frame: got=%h want=0000", tx_frame); end
        if (frame_tx_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid: got=%b want=0", frame_tx_valid); end
        if (ack !== 4'b0)             begin bad++; $display("FAIL rst_ack: got=%b want=0000", ack); end
        if (grant_idx !== 2'd0)       begin bad++; $display("FAIL rst_grant: got=%0d want=0", grant_idx); end
        if (arb_active !== 1'b0)      begin bad++; $display("FAIL rst_active: got=%b want=0", arb_active); end
        if (tx_timeout !== 1'b0)      begin bad++; $display("FAIL rst_timeout: got=%b want=0", tx_timeout); end
    endtask

    task automatic test_single_grant();
        req = 4'b0001;
        @(posedge clk); #1;
        total += 5;
        if (tx_frame !== 16'hA123)    begin bad++; $display("FAIL t1_frame: got=%h want=a123", tx_frame); end
        if (frame_tx_valid !== 1'b1)  begin bad++; $display("FAIL t1_valid: got=%b want=1", frame_tx_valid); end
        if (ack !== 4'b0001)          begin bad++; $display("FAIL t1_ack: got=%b want=0001", ack); end
        if (grant_idx !== 2'd0)       begin bad++; $display("FAIL t1_grant: got=%0d want=0", grant_idx); end
        if (arb_active !== 1'b1)      begin bad++; $display("FAIL t1_active: got=%b want=1", arb_active); end
        req = 4'b0000;
        @(posedge clk); #1;
        total += 2;
        if (frame_tx_valid !== 1'b0)  begin bad++; $display("FAIL t1_valid_width: got=%b want=0", frame_tx_valid); end
        if (ack !== 4'b0000)          begin bad++; $display("FAIL t1_ack_width: got=%b want=0000", ack); end
        wait_idle(60);
    endtask

    task automatic test_rr_order();
        int exp_idx[5];
        exp_idx = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111;
        wait_grants(5, 200);
        for (int i = 0; i < 5 && i < gidx_q.size(); i++) begin
            total++;
            if (gidx_q[i] != exp_idx[i]) begin
                bad++;
                $display("FAIL rr_order[%0d]: got=%0d want=%0d", i, gidx_q[i], exp_idx[i]);
            end
        end
        for (int i = 0; i < 4 && i + 1 < gcyc_q.size(); i++) begin
            total++;
            if (gcyc_q[i+1] - gcyc_q[i] != 21) begin
                bad++;
                $display("FAIL rr_spacing[%0d]: got=%0d want=21", i, gcyc_q[i+1] - gcyc_q[i]);
            end
        end
        req = '0;
        wait_idle(60);
    endtask

    task automatic test_rr_skip();
        int exp_idx[3];
        exp_idx = '{2, 0, 2};
        do_reset();
        req = 4'b0001;
        wait_grants(1, 10);
        req = 4'b0000;
        wait_idle(60);
        gidx_q.delete();
        gcyc_q.delete();
        req = 4'b0101;
        wait_grants(3, 150);
        for (int i = 0; i < 3 && i < gidx_q.size(); i++) begin
            total++;
            if (gidx_q[i] != exp_idx[i]) begin
                bad++;
                $display("FAIL rr_skip[%0d]: got=%0d want=%0d", i, gidx_q[i], exp_idx[i]);
            end
        end
        req = '0;
        wait_idle(60);
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0100;
        wait_grants(2, 100);
        if (gidx_q.size() >= 2) begin
            total += 3;
            if (gidx_q[0] != 2) begin bad++; $display("FAIL b2b_first: got=%0d want=2", gidx_q[0]); end
            if (gidx_q[1] != 2) begin bad++; $display("FAIL b2b_second: got=%0d want=2", gidx_q[1]); end
            if (gcyc_q[1] - gcyc_q[0] != 21) begin
                bad++;
                $display("FAIL b2b_spacing: got=%0d want=21", gcyc_q[1] - gcyc_q[0]);
            end
        end
        req = '0;
        wait_idle(60);
    endtask

    task automatic test_timeout();
        int vcyc;
        int k;
        do_reset();
        ser_en = 1'b0;
        req = 4'b0010;
        wait_grants(1, 10);
        req = 4'b0000;
        vcyc = (gcyc_q.size() > 0) ? gcyc_q[0] : cyc;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!tx_timeout && k < 20);
        total += 3;
        if (tx_timeout !== 1'b1) begin
            bad++;
            $display("FAIL to_seen: tx_timeout=%b want=1", tx_timeout);
        end
        if (cyc - vcyc != 4) begin
            bad++;
            $display("FAIL to_latency: got=%0d want=4", cyc - vcyc);
        end
        if (arb_active !== 1'b0) begin
            bad++;
            $display("FAIL to_idle: arb_active=%b want=0", arb_active);
        end
        @(posedge clk); #1;
        total++;
        if (tx_timeout !== 1'b0) begin
            bad++;
            $display("FAIL to_width: got=%b want=0", tx_timeout);
        end
        ser_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1111;
        wait_grants(2, 60);
        repeat (6) @(negedge clk);
        total++;
        if (tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy: tx_busy=%b want=1", tx_busy);
        end
        #2 rst = 1'b1;
        #1;
        total += 6;
        if (tx_frame !== 16'h0)       begin bad++; $display("FAIL mid_tx_frame: got=%h want=0000", tx_frame); end
        if (frame_tx_valid !== 1'b0)  begin bad++; $display("FAIL mid_valid: got=%b want=0", frame_tx_valid); end
        if (ack !== 4'b0)             begin bad++; $display("FAIL mid_ack: got=%b want=0000", ack); end
        if (grant_idx !== 2'd0)       begin bad++; $display("FAIL mid_grant: got=%0d want=0", grant_idx); end
        if (arb_active !== 1'b0)      begin bad++; $display("FAIL mid_active: got=%b want=0", arb_active); end
        if (tx_timeout !== 1'b0)      begin bad++; $display("FAIL mid_timeout: got=%b want=0", tx_timeout); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        gidx_q.delete();
        gcyc_q.delete();
        wait_grants(1, 10);
        if (gidx_q.size() > 0) begin
            total++;
            if (gidx_q[0] != 0) begin
                bad++;
                $display("FAIL mid_regrant: got=%0d want=0", gidx_q[0]);
            end
        end
        req = '0;
        wait_idle(60);
    endtask

`ifdef EGRESS_ARB_SFD_CHECK_EN
    task automatic test_sfd_drop();
        do_reset();
        frame_in[0*DW +: DW] = 16'h5123;
        frame_in[1*DW +: DW] = 16'hA2F1;
        req = 4'b0011;
        @(posedge clk); #1;
        total += 4;
        if (ack !== 4'b0001)          begin bad++; $display("FAIL sfd_ack: got=%b want=0001", ack); end
        if (drop_pulse !== 1'b1)      begin bad++; $display("FAIL sfd_drop: got=%b want=1", drop_pulse); end
        if (frame_tx_valid !== 1'b0)  begin bad++; $display("FAIL sfd_novalid: got=%b want=0", frame_tx_valid); end
        if (arb_active !== 1'b0)      begin bad++; $display("FAIL sfd_idle: got=%b want=0", arb_active); end
        req = 4'b0010;
        @(posedge clk); #1;
        total += 4;
        if (frame_tx_valid !== 1'b1)  begin bad++; $display("FAIL sfd_next_valid: got=%b want=1", frame_tx_valid); end
        if (tx_frame !== 16'hA2F1)    begin bad++; $display("FAIL sfd_next_frame: got=%h want=a2f1", tx_frame); end
        if (ack !== 4'b0010)          begin bad++; $display("FAIL sfd_next_ack: got=%b want=0010", ack); end
        if (drop_pulse !== 1'b0)      begin bad++; $display("FAIL sfd_drop_width: got=%b want=0", drop_pulse); end
        req = '0;
        wait_idle(60);
        frame_in[0*DW +: DW] = 16'hA123;
        frame_in[1*DW +: DW] = 16'hA456;
    endtask
`endif

    initial begin
        frame_in[0*DW +: DW] = 16'hA123;
        frame_in[1*DW +: DW] = 16'hA456;
        frame_in[2*DW +: DW] = 16'hA789;
        frame_in[3*DW +: DW] = 16'hABCD;
        test_reset();
        test_single_grant();
        test_rr_order();
        test_rr_skip();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
`ifdef EGRESS_ARB_SFD_CHECK_EN
        test_sfd_drop();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
